// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiplier / restoring divider with HI/LO registers.
// Optional MADD/MSUB accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W2 = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [W2-1:0]    mcand_reg, mcand_next;
  logic [W2-1:0]    prod_reg, prod_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] dvsr_reg, dvsr_next;
  logic [WIDTH-1:0] dvnd_reg, dvnd_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic             div0_reg, div0_next;
`ifdef MDU_MADD_EN
  logic             acc_reg, acc_next;
  logic             sub_reg, sub_next;
`endif

  logic             sgn_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    prod_step, prod_fix, hilo_new;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step, quot_step, rem_fix, quot_fix;
  logic             last;
  logic             load;

  // Operand magnitudes for the request currently presented on a/b.
  always_comb begin
    sgn_op = (op == OP_MULT) || (op == OP_DIV) || (op[2:1] == 2'b11);
    a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;
  end

  // One iteration of each datapath, plus the sign fixup used on the final step.
  always_comb begin
    prod_step = prod_reg + (mplier_reg[0] ? mcand_reg : {W2{1'b0}});
    prod_fix  = neg_q_reg ? -prod_step : prod_step;
    trial     = {rem_reg, quot_reg[WIDTH-1]} - {1'b0, dvsr_reg};
    rem_step  = trial[WIDTH] ? {rem_reg[WIDTH-2:0], quot_reg[WIDTH-1]} : trial[WIDTH-1:0];
    quot_step = {quot_reg[WIDTH-2:0], ~trial[WIDTH]};
    quot_fix  = neg_q_reg ? -quot_step : quot_step;
    rem_fix   = neg_r_reg ? -rem_step : rem_step;
    last      = (cnt_reg == CNT_W'(WIDTH - 1));
`ifdef MDU_MADD_EN
    if (acc_reg) begin
      hilo_new = sub_reg ? ({hi_reg, lo_reg} - prod_fix) : ({hi_reg, lo_reg} + prod_fix);
    end else begin
      hilo_new = prod_fix;
    end
`else
    hilo_new = prod_fix;
`endif
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    mcand_next  = mcand_reg;
    prod_next   = prod_reg;
    mplier_next = mplier_reg;
    rem_next    = rem_reg;
    quot_next   = quot_reg;
    dvsr_next   = dvsr_reg;
    dvnd_next   = dvnd_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    div0_next   = div0_reg;
`ifdef MDU_MADD_EN
    acc_next    = acc_reg;
    sub_next    = sub_reg;
`endif
    load        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            OP_MULT, OP_MULTU: begin
              state_next = S_MUL;
              load       = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_next = S_DIV;
              load       = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: begin
              state_next = S_MUL;
              load       = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        if (load) begin
          cnt_next    = '0;
          busy_next   = 1'b1;
          prod_next   = '0;
          mcand_next  = {{WIDTH{1'b0}}, a_mag};
          mplier_next = b_mag;
          rem_next    = '0;
          quot_next   = a_mag;
          dvsr_next   = b_mag;
          dvnd_next   = a;
          neg_q_next  = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_next  = sgn_op && a[WIDTH-1];
          div0_next   = (b == '0);
`ifdef MDU_MADD_EN
          acc_next    = (op == OP_MADD) || (op == OP_MSUB);
          sub_next    = (op == OP_MSUB);
`endif
        end
      end

      S_MUL: begin
        if (flush) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          cnt_next   = '0;
        end else begin
          prod_next   = prod_step;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          cnt_next    = cnt_reg + CNT_W'(1);
          if (last) begin
            {hi_next, lo_next} = hilo_new;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            cnt_next   = '0;
            state_next = S_IDLE;
          end
        end
      end

      S_DIV: begin
        if (flush) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          cnt_next   = '0;
        end else begin
          rem_next  = rem_step;
          quot_next = quot_step;
          cnt_next  = cnt_reg + CNT_W'(1);
          if (last) begin
            // A zero divisor returns the untouched dividend in HI and all ones in LO.
            if (div0_reg) begin
              hi_next = dvnd_reg;
              lo_next = '1;
            end else begin
              hi_next = rem_fix;
              lo_next = quot_fix;
            end
            done_next  = 1'b1;
            busy_next  = 1'b0;
            cnt_next   = '0;
            state_next = S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      mplier_reg <= '0;
      rem_reg    <= '0;
      quot_reg   <= '0;
      dvsr_reg   <= '0;
      dvnd_reg   <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
`ifdef MDU_MADD_EN
      acc_reg    <= 1'b0;
      sub_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      mcand_reg  <= mcand_next;
      prod_reg   <= prod_next;
      mplier_reg <= mplier_next;
      rem_reg    <= rem_next;
      quot_reg   <= quot_next;
      dvsr_reg   <= dvsr_next;
      dvnd_reg   <= dvnd_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      div0_reg   <= div0_next;
`ifdef MDU_MADD_EN
      acc_reg    <= acc_next;
      sub_reg    <= sub_next;
`endif
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed HI/LO values.
module tb_mdu_iter;
  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MTHI  = 3'd4;
  localparam logic [2:0] MTLO  = 3'd5;
  localparam logic [2:0] MADD  = 3'd6;
  localparam logic [2:0] MSUB  = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Reference result computed straight from the arithmetic definition.
  function automatic logic [63:0] calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, rm;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 64'd0;
    case (o)
      MULT, MADD, MSUB: r = 64'(sx * sy);
      MULTU: r = {32'd0, x} * {32'd0, y};
      DIV: begin
        if (y == 32'd0) r = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          rm = sx % sy;
          r = {rm[31:0], q[31:0]};
        end
      end
      DIVU: begin
        if (y == 32'd0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done;
  int          m_left;
  logic [63:0] m_res;
  int          m_acc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_acc <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (flush) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (m_acc == 1) {m_hi, m_lo} <= {m_hi, m_lo} + m_res;
          else if (m_acc == 2) {m_hi, m_lo} <= {m_hi, m_lo} - m_res;
          else {m_hi, m_lo} <= m_res;
        end else m_left <= m_left - 1;
      end else if (start && !flush) begin
        case (op)
          MTHI: m_hi <= a;
          MTLO: m_lo <= a;
          MULT, MULTU, DIV, DIVU: begin
            m_busy <= 1'b1; m_left <= 32; m_acc <= 0; m_res <= calc(op, a, b);
          end
`ifdef MDU_MADD_EN
          MADD, MSUB: begin
            m_busy <= 1'b1; m_left <= 32; m_acc <= (op == MADD) ? 1 : 2; m_res <= calc(op, a, b);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      total++;
      if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
        bad++;
        $display("FAIL model cyc=%0d got busy=%0b done=%0b hi=%h lo=%h want busy=%0b done=%0b hi=%h lo=%h",
                 cyc, busy, done, hi, lo, m_busy, m_done, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic fl);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; a = $urandom; b = $urandom;
    $display("txn op=%0d a=%h b=%h flush=%0b -> busy=%0b hi=%h lo=%h", o, x, y, fl, busy, hi, lo);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL busy_timeout got=busy want=idle");
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    int n, d0;
    d0 = done_cnt;
    issue(o, x, y, 1'b0);
    wait_idle(n);
    @(negedge clk);
    chk({nm, "_cycles"}, 32'(n), 32'd32);
    chk({nm, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
  endtask

  initial begin
    int n, d0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;

    // Reset after arbitrary activity.
    issue(MTHI, 32'h55, 32'h0, 1'b0);
    issue(MTLO, 32'h66, 32'h0, 1'b0);
    issue(MULTU, 32'd3, 32'd4, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Reset while a multiply is in flight.
    d0 = done_cnt;
    issue(MULT, 32'd6, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);

    run_op("mult", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", DIVU, 32'h64, 32'd0, 32'h64, 32'hFFFFFFFF);
    run_op("div0s", DIV, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF);
    run_op("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // MTHI is immediate; flush aborts a multiply leaving HI/LO alone.
    issue(MTHI, 32'h1234, 32'h0, 1'b0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_done", 32'(done), 32'd0);
    d0 = done_cnt;
    issue(MULTU, 32'd7, 32'd9, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_done", 32'(done_cnt - d0), 32'd0);
    chk("flush_hi", hi, 32'h1234);

    // Flush together with start in IDLE drops the request.
    d0 = done_cnt;
    issue(MULT, 32'd2, 32'd3, 1'b1);
    chk("flushstart_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("flushstart_done", 32'(done_cnt - d0), 32'd0);

    // A second start while busy is ignored.
    d0 = done_cnt;
    issue(MULTU, 32'd3, 32'd5, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    repeat (5) @(negedge clk);
    chk("busystart_done", 32'(done_cnt - d0), 32'd1);
    chk("busystart_lo", lo, 32'd15);
    chk("busystart_hi", hi, 32'd0);
    chk("busystart_idle", 32'(busy), 32'd0);

    run_op("ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

`ifdef MDU_MADD_EN
    issue(MTLO, 32'd10, 32'd0, 1'b0);
    issue(MTHI, 32'd0, 32'd0, 1'b0);
    run_op("madd", MADD, 32'd3, 32'd4, 32'd0, 32'd22);
    run_op("msub", MSUB, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd23);
`else
    issue(MTHI, 32'hAA, 32'd0, 1'b0);
    issue(MTLO, 32'hBB, 32'd0, 1'b0);
    d0 = done_cnt;
    issue(MADD, 32'd3, 32'd4, 1'b0);
    chk("op6_busy", 32'(busy), 32'd0);
    issue(MSUB, 32'd3, 32'd4, 1'b0);
    chk("op7_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("op67_done", 32'(done_cnt - d0), 32'd0);
    chk("op67_hi", hi, 32'hAA);
    chk("op67_lo", lo, 32'hBB);
`endif

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the single-cycle ALU in the EX stage.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO per request and computes multiplies and divides over WIDTH cycles, with a start/busy/done handshake.
- The pipeline stalls on busy, and MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32: operand width; hi and lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      synchronous active-low reset, sampled on rising clk
- start  input   1      request valid; sampled only when busy=0
- op     input   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
- a      input   WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO source)
- b      input   WIDTH  operand rt (divisor / multiplier)
- flush  input   1      abort in-flight op; HI/LO keep their old values
- busy   output  1      registered; high while iterating
- done   output  1      registered one-cycle pulse when a MUL/DIV result is written
- hi     output  WIDTH  HI register
- lo     output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; counter and internal datapath registers cleared.
  - Applies mid-operation: the op is discarded.
- States and transitions:
  - IDLE: start=1 and flush=0 at edge T:
    - MTHI: hi<=a at T, no busy, no done.
    - MTLO: lo<=a at T, no busy, no done.
    - MULT/MULTU/MADD/MSUB: go to MUL and latch operand magnitudes and sign flags.
    - DIV/DIVU: go to DIV and latch operand magnitudes and sign flags.
    - Either of those: busy=1 from T, counter=0.
  - MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit partial product.
  - DIV: restoring divide, one quotient bit per cycle.
  - Completion: on the edge where counter reaches WIDTH-1, which is edge T+WIDTH:
    - apply sign fixup and write hi/lo;
    - busy<=0, done<=1 for exactly one cycle; return to IDLE.
  - Total latency: result visible WIDTH cycles after the accept edge.
- Signed ops:
  - Operands are converted to magnitudes (two's complement negate if MSB=1).
  - Product is negated if sign(a)^sign(b).
  - Quotient is negated if sign(a)^sign(b); remainder takes sign(a).
  - MULTU/DIVU: no conversion.
- Results:
  - Multiply: {hi,lo} = 2*WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (b=0, signed or unsigned): still takes WIDTH cycles; hi = a (original value), lo = all ones.
- Signed overflow (a = 1<<(WIDTH-1), b = -1): lo = 1<<(WIDTH-1), hi = 0.
- start while busy=1: ignored, no queueing. The pipeline must hold the request until busy=0.
- flush:
  - In MUL/DIV: return to IDLE next edge, busy<=0, no done, hi/lo unchanged.
  - Flush together with start in IDLE: the request is dropped.
  - Flush on the completion edge: flush wins, no write.
- Operands a/b may change after the accept edge; the internal latches are used.
- No output is combinational from inputs.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 110 MADD: {hi,lo} <= {hi,lo} + signed product.
  - op 111 MSUB: {hi,lo} <= {hi,lo} - signed product.
  - Both use the MUL path and the same WIDTH-cycle latency.
  - The accumulate uses the HI/LO values held at completion, not at accept.
  - The add/subtract is modulo 2^(2*WIDTH).
- Not defined: ops 110/111 are ignored when start=1 in IDLE; busy stays 0, no done, hi/lo unchanged.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles after arbitrary ops -> hi=0, lo=0, busy=0, done=0. Then MULT mid-flight at cycle 5 followed by rst_n=0 -> same reset values, no done.
- MULT a=0xFFFFFFFD (-3), b=5; MULTU a=b=0xFFFFFFFF:
  - MULT -> busy for 32 cycles, done pulse once, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - MULTU -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=0x64, b=0 -> hi=0x64, lo=0xFFFFFFFF after 32 cycles.
- Sequencing:
  - MTHI a=0x1234 -> hi=0x1234 next cycle, busy/done stay 0.
  - Then MULTU 7*9 with flush at cycle 10 -> busy drops, no done, hi=0x1234.
  - Second start asserted during busy -> ignored; only one done is seen.
- Signed overflow DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- With MDU_MADD_EN: MTLO 10, MTHI 0, MADD 3*4 -> lo=22, hi=0; then MSUB 0xFFFFFFFF*1 -> lo=23.
- Without MDU_MADD_EN: op 110 start -> busy stays 0, hi/lo unchanged.
